// File: rtl/reg_mem_responder_pkg.sv
// Shared types for the memory-side responder.
//   resp_state_e : responder FSM state encoding.
package reg_mem_responder_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACCESS,
    WAIT,
    ACK,
    DONE
  } resp_state_e;

endpackage

// File: rtl/reg_mem_responder.sv
// Memory-side responder: serves one level-held request on a single-port
// synchronous SRAM and returns exactly one completion pulse per request.
//
// State  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for mem_req_vld; latch and classify the request
// ACCESS | one SRAM cycle (sram_ce=1, sram_we=latched write)
// WAIT   | read latency; capture sram_rdata when the counter hits 0
// ACK    | one-cycle mem_ack_vld with err/rd_data
// DONE   | wait for the requester to drop mem_req_vld
//
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   mem_req_vld/addr/wr_en/rd_en/
//   mem_wr_data                      : level-held request from the bridge
//   mem_ack_vld, mem_err, mem_rd_data: completion; err/data zero without ack
//   sram_ce/we/addr/wdata, sram_rdata: SRAM port
//   err_cnt                          : saturating count of errored requests
//
// Parameter constraints: MEM_DEPTH <= 2**MEM_ADDR_WIDTH, SRAM_RD_LATENCY >= 1.
module reg_mem_responder
  import reg_mem_responder_pkg::*;
#(
  parameter int MEM_DATA_WIDTH  = 64,
  parameter int MEM_ADDR_WIDTH  = 5,
  parameter int MEM_DEPTH       = 32,
  parameter int SRAM_RD_LATENCY = 1,
  parameter int ERR_CNT_WIDTH   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mem_req_vld,
  input  logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  input  logic                      mem_wr_en,
  input  logic                      mem_rd_en,
  input  logic [MEM_DATA_WIDTH-1:0] mem_wr_data,
  output logic                      mem_ack_vld,
  output logic                      mem_err,
  output logic [MEM_DATA_WIDTH-1:0] mem_rd_data,
  output logic                      sram_ce,
  output logic                      sram_we,
  output logic [MEM_ADDR_WIDTH-1:0] sram_addr,
  output logic [MEM_DATA_WIDTH-1:0] sram_wdata,
  input  logic [MEM_DATA_WIDTH-1:0] sram_rdata,
  output logic [ERR_CNT_WIDTH-1:0]  err_cnt
);

  localparam int                LAT_W    = $clog2(SRAM_RD_LATENCY + 1);
  localparam logic [LAT_W-1:0]  LAT_LOAD = LAT_W'(SRAM_RD_LATENCY - 1);

  resp_state_e               state_q, state_d;
  logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                      wr_q, wr_d;
  logic [MEM_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [MEM_DATA_WIDTH-1:0] rd_q, rd_d;
  logic                      err_q, err_d;
  logic [LAT_W-1:0]          lat_q, lat_d;
  logic [ERR_CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d;
  logic                      addr_oob;
  logic                      req_err;

  assign addr_oob = (32'(mem_addr) >= 32'(MEM_DEPTH));

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wr_d      = wr_q;
    wdata_d   = wdata_q;
    rd_d      = rd_q;
    err_d     = err_q;
    lat_d     = lat_q;
    err_cnt_d = err_cnt_q;
    // A legal request has exactly one of wr_en/rd_en set, so after
    // classification the read direction is simply !wr_q.
    req_err   = addr_oob || (mem_wr_en == mem_rd_en);

    unique case (state_q)
      IDLE: begin
        if (mem_req_vld) begin
          addr_d  = mem_addr;
          wr_d    = mem_wr_en;
          wdata_d = mem_wr_data;
          rd_d    = '0;
          err_d   = req_err;
          state_d = req_err ? ACK : ACCESS;
        end
      end
      ACCESS: begin
        if (wr_q) begin
          state_d = ACK;
        end else begin
          lat_d   = LAT_LOAD;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (lat_q == '0) begin
          rd_d    = sram_rdata;
          state_d = ACK;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      ACK: begin
        state_d = DONE;
      end
      DONE: begin
        if (!mem_req_vld) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if ((state_d == ACK) && (state_q != ACK) && err_d && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      rd_q      <= '0;
      err_q     <= 1'b0;
      lat_q     <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      wdata_q   <= wdata_d;
      rd_q      <= rd_d;
      err_q     <= err_d;
      lat_q     <= lat_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // err/rd_data cross domains as pulses downstream, so they must be zero
  // whenever there is no ack.
  assign mem_ack_vld = (state_q == ACK);
  assign mem_err     = mem_ack_vld & err_q;
  assign mem_rd_data = mem_ack_vld ? rd_q : '0;

  assign sram_ce    = (state_q == ACCESS);
  assign sram_we    = sram_ce & wr_q;
  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;

  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_reg_mem_responder.sv
module tb_reg_mem_responder;

  localparam int DW    = 64;
  localparam int AW    = 5;
  localparam int DEPTH = 20;

  localparam logic [DW-1:0] D1 = 64'hDEAD_BEEF_0123_4567;
  localparam logic [DW-1:0] D2 = 64'h0F0F_1234_5678_9ABC;
  localparam logic [DW-1:0] D3 = 64'hA5A5_5A5A_0000_FFFF;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_req_vld;
  logic [AW-1:0] mem_addr;
  logic          mem_wr_en;
  logic          mem_rd_en;
  logic [DW-1:0] mem_wr_data;

  logic          ack_a, err_a, ce_a, we_a;
  logic [DW-1:0] rdata_out_a, wdata_a, sram_rdata_a;
  logic [AW-1:0] saddr_a;
  logic [15:0]   err_cnt_a;

  logic          ack_b, err_b, ce_b, we_b;
  logic [DW-1:0] rdata_out_b, wdata_b, sram_rdata_b;
  logic [AW-1:0] saddr_b;
  logic [1:0]    err_cnt_b;

  always #5 clk = ~clk;

  reg_mem_responder #(
    .MEM_DATA_WIDTH(DW), .MEM_ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH),
    .SRAM_RD_LATENCY(1), .ERR_CNT_WIDTH(16)
  ) dut_a (
    .clk(clk), .rst(rst),
    .mem_req_vld(mem_req_vld), .mem_addr(mem_addr), .mem_wr_en(mem_wr_en),
    .mem_rd_en(mem_rd_en), .mem_wr_data(mem_wr_data),
    .mem_ack_vld(ack_a), .mem_err(err_a), .mem_rd_data(rdata_out_a),
    .sram_ce(ce_a), .sram_we(we_a), .sram_addr(saddr_a), .sram_wdata(wdata_a),
    .sram_rdata(sram_rdata_a), .err_cnt(err_cnt_a)
  );

  reg_mem_responder #(
    .MEM_DATA_WIDTH(DW), .MEM_ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH),
    .SRAM_RD_LATENCY(3), .ERR_CNT_WIDTH(2)
  ) dut_b (
    .clk(clk), .rst(rst),
    .mem_req_vld(mem_req_vld), .mem_addr(mem_addr), .mem_wr_en(mem_wr_en),
    .mem_rd_en(mem_rd_en), .mem_wr_data(mem_wr_data),
    .mem_ack_vld(ack_b), .mem_err(err_b), .mem_rd_data(rdata_out_b),
    .sram_ce(ce_b), .sram_we(we_b), .sram_addr(saddr_b), .sram_wdata(wdata_b),
    .sram_rdata(sram_rdata_b), .err_cnt(err_cnt_b)
  );

  // SRAM models: read data is valid only exactly LAT cycles after sram_ce.
  logic [DW-1:0] mem_a [32];
  logic [DW-1:0] mem_b [32];
  logic [DW-1:0] pipe_a;
  logic [DW-1:0] pipe_b [3];

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    pipe_a = '0;
    for (int i = 0; i < 3; i++) pipe_b[i] = '0;
  end

  always @(posedge clk) begin
    if (ce_a && we_a) mem_a[saddr_a] <= wdata_a;
    pipe_a <= (ce_a && !we_a) ? mem_a[saddr_a] : '0;
    if (ce_b && we_b) mem_b[saddr_b] <= wdata_b;
    pipe_b[0] <= (ce_b && !we_b) ? mem_b[saddr_b] : '0;
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end

  assign sram_rdata_a = pipe_a;
  assign sram_rdata_b = pipe_b[2];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one request at the current cycle (cycle 0) and watches both
  // responders until the request has been dropped and settled.
  task automatic run_req(input string tag, input logic [AW-1:0] addr,
                         input logic wr, input logic rd, input logic [DW-1:0] wdata,
                         input int hold, input int exp_ack_a, input int exp_ack_b,
                         input logic exp_err, input logic [DW-1:0] exp_rd,
                         input logic exp_ce);
    int n_ack_a = 0, n_ack_b = 0, cyc_a = -1, cyc_b = -1;
    int n_ce_a = 0, n_ce_b = 0, ce_cyc = -1, viol = 0, drop_c = -1, max_ack;
    logic e_a = 1'b0, e_b = 1'b0, ce_we = 1'b0;
    logic [DW-1:0] r_a = '0, r_b = '0, ce_wd = '0;
    logic [AW-1:0] ce_addr = '0;

    mem_req_vld = 1'b1;
    mem_addr    = addr;
    mem_wr_en   = wr;
    mem_rd_en   = rd;
    mem_wr_data = wdata;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ack_a) begin
        n_ack_a++;
        if (n_ack_a == 1) begin cyc_a = c; e_a = err_a; r_a = rdata_out_a; end
      end else if (err_a || rdata_out_a != '0) viol++;
      if (ack_b) begin
        n_ack_b++;
        if (n_ack_b == 1) begin cyc_b = c; e_b = err_b; r_b = rdata_out_b; end
      end else if (err_b || rdata_out_b != '0) viol++;
      if (ce_a) begin
        n_ce_a++;
        if (n_ce_a == 1) begin ce_cyc = c; ce_we = we_a; ce_addr = saddr_a; ce_wd = wdata_a; end
      end
      if (ce_b) n_ce_b++;
      @(posedge clk);
      #1;
      max_ack = (cyc_a > cyc_b) ? cyc_a : cyc_b;
      if (mem_req_vld && n_ack_a > 0 && n_ack_b > 0 && c >= max_ack + hold) begin
        mem_req_vld = 1'b0;
        drop_c = c;
      end
      if (drop_c >= 0 && c >= drop_c + 3) break;
    end
    if (drop_c < 0) begin
      mem_req_vld = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
    end

    check({tag, " ack_cyc_a"}, 64'(cyc_a), 64'(exp_ack_a));
    check({tag, " ack_cyc_b"}, 64'(cyc_b), 64'(exp_ack_b));
    check({tag, " n_ack_a"}, 64'(n_ack_a), 64'd1);
    check({tag, " n_ack_b"}, 64'(n_ack_b), 64'd1);
    check({tag, " err_a"}, 64'(e_a), 64'(exp_err));
    check({tag, " err_b"}, 64'(e_b), 64'(exp_err));
    check({tag, " rd_a"}, r_a, exp_rd);
    check({tag, " rd_b"}, r_b, exp_rd);
    check({tag, " n_ce_a"}, 64'(n_ce_a), 64'(exp_ce));
    check({tag, " n_ce_b"}, 64'(n_ce_b), 64'(exp_ce));
    check({tag, " nonack_zero"}, 64'(viol), 64'd0);
    if (exp_ce) begin
      check({tag, " ce_cyc"}, 64'(ce_cyc), 64'd1);
      check({tag, " ce_we"}, 64'(ce_we), 64'(wr));
      check({tag, " ce_addr"}, 64'(ce_addr), 64'(addr));
      if (wr) check({tag, " ce_wdata"}, ce_wd, wdata);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    mem_req_vld = 1'b0;
    mem_addr = '0;
    mem_wr_en = 1'b0;
    mem_rd_en = 1'b0;
    mem_wr_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst ack", {62'd0, ack_b, ack_a}, 64'd0);
    check("rst err", {62'd0, err_b, err_a}, 64'd0);
    check("rst rd_data", rdata_out_a | rdata_out_b, 64'd0);
    check("rst sram_ctl", {60'd0, ce_b, we_b, ce_a, we_a}, 64'd0);
    check("rst sram_addr", 64'(saddr_a | saddr_b), 64'd0);
    check("rst sram_wdata", wdata_a | wdata_b, 64'd0);
    check("rst err_cnt", {46'd0, err_cnt_b, err_cnt_a}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_req("wr3",  5'd3,  1'b1, 1'b0, D1, 0, 2, 2, 1'b0, '0, 1'b1);
    run_req("rd3",  5'd3,  1'b0, 1'b1, '0, 0, 3, 5, 1'b0, D1, 1'b1);
    run_req("wr19", 5'd19, 1'b1, 1'b0, D2, 0, 2, 2, 1'b0, '0, 1'b1);
    run_req("rd19", 5'd19, 1'b0, 1'b1, '0, 0, 3, 5, 1'b0, D2, 1'b1);
    run_req("wr5_hold", 5'd5, 1'b1, 1'b0, D3, 4, 2, 2, 1'b0, '0, 1'b1);
    run_req("rd5_hold", 5'd5, 1'b0, 1'b1, '0, 4, 3, 5, 1'b0, D3, 1'b1);

    run_req("err_a31", 5'd31, 1'b1, 1'b0, D2, 0, 1, 1, 1'b1, '0, 1'b0);
    check("err_cnt_a pre_rst", 64'(err_cnt_a), 64'd1);
    check("err_cnt_b pre_rst", 64'(err_cnt_b), 64'd1);

    // Reset in the WAIT phase of a read, with the request kept held.
    mem_req_vld = 1'b1;
    mem_addr    = 5'd3;
    mem_wr_en   = 1'b0;
    mem_rd_en   = 1'b1;
    mem_wr_data = '0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("abort ack", {62'd0, ack_b, ack_a}, 64'd0);
    check("abort rd_data", rdata_out_a | rdata_out_b, 64'd0);
    check("abort sram_ce", {62'd0, ce_b, ce_a}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_req("rst_reserve", 5'd3, 1'b0, 1'b1, '0, 0, 3, 5, 1'b0, D1, 1'b1);
    check("err_cnt_a post_rst", 64'(err_cnt_a), 64'd0);
    check("err_cnt_b post_rst", 64'(err_cnt_b), 64'd0);

    run_req("err_a31b", 5'd31, 1'b0, 1'b1, '0, 0, 1, 1, 1'b1, '0, 1'b0);
    run_req("err_both", 5'd3,  1'b1, 1'b1, D3, 0, 1, 1, 1'b1, '0, 1'b0);
    run_req("err_none", 5'd3,  1'b0, 1'b0, D3, 0, 1, 1, 1'b1, '0, 1'b0);
    check("err_cnt_a three", 64'(err_cnt_a), 64'd3);
    check("err_cnt_b three", 64'(err_cnt_b), 64'd3);
    run_req("err_a20", 5'd20, 1'b1, 1'b0, D1, 0, 1, 1, 1'b1, '0, 1'b0);
    check("err_cnt_a four", 64'(err_cnt_a), 64'd4);
    check("err_cnt_b sat", 64'(err_cnt_b), 64'd3);
    run_req("err_s1", 5'd25, 1'b0, 1'b1, '0, 0, 1, 1, 1'b1, '0, 1'b0);
    run_req("err_s2", 5'd7,  1'b1, 1'b1, D2, 0, 1, 1, 1'b1, '0, 1'b0);
    run_req("err_s3", 5'd0,  1'b0, 1'b0, '0, 0, 1, 1, 1'b1, '0, 1'b0);
    run_req("err_s4", 5'd21, 1'b1, 1'b0, D1, 2, 1, 1, 1'b1, '0, 1'b0);
    check("err_cnt_a eight", 64'(err_cnt_a), 64'd8);
    check("err_cnt_b sat_hold", 64'(err_cnt_b), 64'd3);

    // Data at addr 3 untouched by the rejected both-enables write.
    run_req("rd3_final", 5'd3, 1'b0, 1'b1, '0, 0, 3, 5, 1'b0, D1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
